// File: rtl/mips_mem_arbiter.sv
// ---------------------------------------------------------------------------
// mips_mem_arbiter
//
// Single-port memory arbiter for the two-clock MIPS pipeline. The unified
// 1024x32 word-addressed memory is shared between the instruction-fetch port
// (IF stage) and the data port (MEM stage, LW/SW). Exactly one transaction is
// in flight at a time:
//
//   IDLE/DONE --arbitrate--> ISSUE (mem_en, gnt) --> WAIT x MEM_LAT --> DONE
//
// The data port wins simultaneous requests because the MEM stage holds the
// older instruction. Re-arbitration happens in DONE, so back-to-back
// transactions carry no idle gap: one transaction per MEM_LAT+2 cycles.
//
// Optional feature macro: ARB_FAIRNESS_EN
//   defined   : a saturating starvation counter lets a waiting fetch win after
//               STARVE_MAX consecutive data grants.
//   undefined : strict data priority; the counter is absent and a fetch can
//               starve under continuous data demand.
//
// Reset is synchronous and active-high; it wins over every simultaneous
// event and discards any in-flight access (no rvalid, late mem_rdata ignored).
// ---------------------------------------------------------------------------
module mips_mem_arbiter #(
  parameter int AW         = 10, // memory word-address width
  parameter int DW         = 32, // data width
  parameter int MEM_LAT    = 1,  // mem_en to valid mem_rdata, 1..7 cycles
  parameter int STARVE_MAX = 4   // data grants tolerated while fetch waits, 1..15
) (
  input  logic          clk,
  input  logic          reset,

  // Instruction-fetch port
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,

  // Data port (LW/SW)
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [DW-1:0] dm_rdata,

  // Memory side
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,

  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  // Latched transaction: owner, direction, address and store data.
  logic          r_owner_dm;   // 1 = data port owns the current transaction
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;

  // Counts down the remaining WAIT cycles; 0 marks the capture edge.
  logic [2:0]    r_wait_cnt;

  // Per-requester read data, held until that requester's next read completes.
  logic [DW-1:0] r_if_rdata;
  logic [DW-1:0] r_dm_rdata;

  // Arbitration decision, meaningful only on the edge that ends IDLE or DONE.
  logic          w_arb_edge;
  logic          w_force_if;
  logic          w_pick_dm;
  logic          w_pick_if;
  logic          w_last_wait;

  assign w_arb_edge  = (r_state == IDLE) || (r_state == DONE);
  assign w_last_wait = (r_state == WAIT) && (r_wait_cnt == 3'd0);

`ifdef ARB_FAIRNESS_EN
  // Consecutive data grants issued while a fetch was waiting (saturating).
  logic [3:0] r_starve_cnt;

  assign w_force_if = if_req && dm_req && (r_starve_cnt == 4'(STARVE_MAX));

  // Starvation counter: bump on a data grant that overtakes a waiting fetch,
  // clear on a fetch grant or whenever no fetch is waiting at arbitration.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve_cnt <= 4'd0;
    end else if (w_arb_edge) begin
      if (!if_req || w_pick_if) begin
        r_starve_cnt <= 4'd0;
      end else if (w_pick_dm && (r_starve_cnt != 4'(STARVE_MAX))) begin
        r_starve_cnt <= r_starve_cnt + 4'd1;
      end
    end
  end
`else
  logic w_unused_starve;

  assign w_force_if      = 1'b0;
  assign w_unused_starve = ^4'(STARVE_MAX);
`endif

  // Data beats fetch unless the fairness counter hands this slot to fetch.
  assign w_pick_dm = dm_req && !w_force_if;
  assign w_pick_if = if_req && !w_pick_dm;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: state elements use non-blocking assignments so every flop samples
    // the pre-edge values of its inputs, independent of block ordering.
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-cycle strobes decoded from the current state.
  always_comb begin
    // NOTE: every output of this block is given a default first, so no path
    // through the case statement leaves a signal unassigned (no latches).
    w_state_nxt = r_state;
    mem_en      = 1'b0;
    if_gnt      = 1'b0;
    dm_gnt      = 1'b0;
    if_rvalid   = 1'b0;
    dm_rvalid   = 1'b0;

    case (r_state)
      IDLE: begin
        w_state_nxt = (if_req || dm_req) ? ISSUE : IDLE;
      end
      ISSUE: begin
        mem_en      = 1'b1;
        dm_gnt      = r_owner_dm;
        if_gnt      = !r_owner_dm;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        if (r_wait_cnt == 3'd0) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        dm_rvalid   = r_owner_dm;
        if_rvalid   = !r_owner_dm;
        w_state_nxt = (if_req || dm_req) ? ISSUE : IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Transaction latch, wait counter and read-data capture.
  always_ff @(posedge clk) begin
    // NOTE: the datapath registers are reset as well, because their reset
    // value is visible on mem_addr/mem_wdata and on both rdata outputs.
    if (reset) begin
      r_owner_dm <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wait_cnt <= 3'd0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
    end else begin
      if (w_arb_edge) begin
        if (w_pick_dm) begin
          r_owner_dm <= 1'b1;
          r_we       <= dm_we;
          r_addr     <= dm_addr;
          r_wdata    <= dm_wdata;
        end else if (w_pick_if) begin
          // A fetch is always a read; store data is left as it was.
          r_owner_dm <= 1'b0;
          r_we       <= 1'b0;
          r_addr     <= if_addr;
        end
      end

      if (r_state == ISSUE) begin
        r_wait_cnt <= 3'(MEM_LAT - 1);
      end else if ((r_state == WAIT) && (r_wait_cnt != 3'd0)) begin
        r_wait_cnt <= r_wait_cnt - 3'd1;
      end

      // Capture straight into the owner's rdata so it is valid with rvalid.
      // Stores leave dm_rdata untouched.
      if (w_last_wait && !r_we) begin
        if (r_owner_dm) begin
          r_dm_rdata <= mem_rdata;
        end else begin
          r_if_rdata <= mem_rdata;
        end
      end
    end
  end

  // Memory-side outputs come straight from the latch; they are stable and
  // only meaningful while mem_en is high.
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

  assign if_rdata  = r_if_rdata;
  assign dm_rdata  = r_dm_rdata;
  assign busy      = (r_state != IDLE);

endmodule
